hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Generates the enable and flush controls for the F/D/E/M/W pipeline registers. It also generates the execute-stage forwarding selects.
- Adds a valid/ready handshake to a multi-cycle data memory, which freezes the whole pipeline until the access completes.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- REGISTER_ADDR_SIZE, 5: width of register-file addresses.
- CNT_WIDTH, 16: width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- Rs1D_i, Rs2D_i  in  REGISTER_ADDR_SIZE  source registers in decode.
- Rs1E_i, Rs2E_i  in  REGISTER_ADDR_SIZE  source registers in execute.
- RdE_i, RdM_i, RdW_i  in  REGISTER_ADDR_SIZE  destination registers in E/M/W.
- ResultSrcE_i  in  2  result select in execute; 2'b01 marks a load.
- RegWriteM_i, RegWriteW_i  in  1  register-write enables in M/W.
- PCSrcE_i  in  1  taken branch or jump resolved in execute.
- MemReqM_i  in  1  memory stage holds a load or store.
- mem_ready_i  in  1  data memory completes the access this cycle.
- mem_valid_o  out  1  request to data memory.
- EnF_o, EnD_o, EnE_o, EnM_o, EnW_o  out  1  pipeline register enables; 0 freezes the stage.
- FlushD_o, FlushE_o  out  1  clear D/E registers to a bubble.
- ForwardAE_o, ForwardBE_o  out  2  ALU operand select: 00 register file, 01 W result, 10 M ALU result.
- stall_cnt_o  out  CNT_WIDTH  number of frozen or stalled cycles.

Behaviour:
- Forwarding (combinational):
  - ForwardAE_o = 10 when RegWriteM_i, RdM_i != 0 and RdM_i == Rs1E_i.
  - Otherwise 01 when RegWriteW_i, RdW_i != 0 and RdW_i == Rs1E_i.
  - Otherwise 00.
  - M has priority over W. ForwardBE_o uses the same rules on Rs2E_i.
- Memory FSM, states RUN and MEM_WAIT:
  - RUN: mem_valid_o = MemReqM_i. If MemReqM_i and !mem_ready_i, go to MEM_WAIT next cycle. A same-cycle ready completes with no stall.
  - MEM_WAIT: mem_valid_o = 1, held stable. On mem_ready_i return to RUN next cycle.
- Freeze:
  - mem_freeze = mem_valid_o && !mem_ready_i.
  - While mem_freeze, all En*_o = 0 and FlushD_o = FlushE_o = 0.
  - PCSrcE_i stays stable while frozen. Any branch flush is applied in the first unfrozen cycle.
- Load-use stall, lwStall:
  - Condition: ResultSrcE_i == 01, RdE_i != 0, and (RdE_i == Rs1D_i or RdE_i == Rs2D_i).
  - Response: EnF_o = EnD_o = 0 and FlushE_o = 1. EnE_o, EnM_o and EnW_o stay 1.
  - Latency is exactly one bubble per hazard.
- Branch or jump (PCSrcE_i):
  - FlushD_o = FlushE_o = 1, with all enables 1.
  - PCSrcE_i overrides lwStall: the decode instruction is discarded anyway, and the PC must load the target.
- Priority: mem_freeze > PCSrcE_i > lwStall > normal. In normal operation all enables are 1 and no flushes.
- stall_cnt_o:
  - Increments by 1 each cycle where mem_freeze or (lwStall and !PCSrcE_i) holds.
  - Saturates at all-ones and never wraps.
- Reset (rst_i high):
  - State goes to RUN on the next edge; stall_cnt_o is cleared to 0.
  - While rst_i is high, outputs are forced: mem_valid_o = 0, all En*_o = 1, FlushD_o = FlushE_o = 1, forwarding selects = 00.
  - A reset during MEM_WAIT abandons the access. The memory must tolerate valid dropping in this case only.
- After reset, the first cycle with rst_i low is normal RUN behaviour.

Decomposition:
- Shared package pipeline_pkg:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - mem_state_t enum: RUN, MEM_WAIT.
  - Constant RESULT_SRC_LOAD = 2'b01.
- Sub-module fwd_unit: combinational, instantiated twice, once each for Rs1E_i and Rs2E_i. It makes the M/W priority rule and the x0 exclusion a single checked block.
- FSM, stall logic and counter stay in hazard_ctrl.

Test Plan:
- Forwarding priority: RdM = RdW = Rs1E = 5, RegWriteM = RegWriteW = 1 -> ForwardAE = 10. Drop RegWriteM -> 01. Set Rd = 0 with both writes set -> 00.
- Load-use: ResultSrcE = 01, RdE = 3, Rs2D = 3 -> one cycle with EnF = EnD = 0, FlushE = 1. Next cycle with ResultSrcE = 00 -> all enables 1. stall_cnt increments by exactly 1.
- Branch vs load-use: lwStall condition and PCSrcE = 1 in the same cycle -> EnF = EnD = 1, FlushD = FlushE = 1. stall_cnt unchanged.
- Memory wait: MemReqM = 1, mem_ready low for 3 cycles then high -> mem_valid high 4 cycles, all enables 0 for 3 cycles. State is MEM_WAIT from cycle 2 and RUN after ready. stall_cnt += 3.
- Freeze with pending branch: PCSrcE = 1 during a 2-cycle memory wait -> no flush while frozen. FlushD = FlushE = 1 in the ready cycle.
- Reset and saturation: rst_i asserted in MEM_WAIT -> mem_valid = 0 immediately, state RUN, stall_cnt = 0. With CNT_WIDTH = 4, 20 frozen cycles -> stall_cnt holds at 15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: forwarding selects, memory FSM states, result-source codes.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/fwd_unit.sv
// Execute-stage forwarding select for one ALU source operand.
// Ports:
//   rs_i                       source register in execute
//   rd_m_i, reg_write_m_i      destination / write enable in memory stage
//   rd_w_i, reg_write_w_i      destination / write enable in writeback stage
//   fwd_o                      operand select (FWD_RF / FWD_W / FWD_M)
module fwd_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs_i,
  input  logic [ADDR_W-1:0] rd_m_i,
  input  logic [ADDR_W-1:0] rd_w_i,
  input  logic              reg_write_m_i,
  input  logic              reg_write_w_i,
  output logic [1:0]        fwd_o
);

  // M is younger than W, so it wins; x0 is never forwarded.
  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
      fwd_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Generates F/D/E/M/W enables, D/E flushes, execute forwarding selects,
// a valid/ready handshake to a multi-cycle data memory, and a saturating
// stall-cycle counter.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   Rs1D_i, Rs2D_i            decode source registers
//   Rs1E_i, Rs2E_i            execute source registers
//   RdE_i, RdM_i, RdW_i       destination registers in E/M/W
//   ResultSrcE_i              execute result select (load = 2'b01)
//   RegWriteM_i, RegWriteW_i  register-write enables in M/W
//   PCSrcE_i                  taken branch/jump resolved in execute
//   MemReqM_i, mem_ready_i    memory-stage access request / memory done
//   mem_valid_o               request to data memory
//   En{F,D,E,M,W}_o           pipeline register enables
//   FlushD_o, FlushE_o        bubble insertion for D/E
//   ForwardAE_o, ForwardBE_o  ALU operand selects
//   stall_cnt_o               frozen or stalled cycle count
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned REGISTER_ADDR_SIZE = 5,
  parameter int unsigned CNT_WIDTH          = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [REGISTER_ADDR_SIZE-1:0] Rs1D_i,
  input  logic [REGISTER_ADDR_SIZE-1:0] Rs2D_i,
  input  logic [REGISTER_ADDR_SIZE-1:0] Rs1E_i,
  input  logic [REGISTER_ADDR_SIZE-1:0] Rs2E_i,
  input  logic [REGISTER_ADDR_SIZE-1:0] RdE_i,
  input  logic [REGISTER_ADDR_SIZE-1:0] RdM_i,
  input  logic [REGISTER_ADDR_SIZE-1:0] RdW_i,
  input  logic [1:0]                    ResultSrcE_i,
  input  logic                          RegWriteM_i,
  input  logic                          RegWriteW_i,
  input  logic                          PCSrcE_i,
  input  logic                          MemReqM_i,
  input  logic                          mem_ready_i,
  output logic                          mem_valid_o,
  output logic                          EnF_o,
  output logic                          EnD_o,
  output logic                          EnE_o,
  output logic                          EnM_o,
  output logic                          EnW_o,
  output logic                          FlushD_o,
  output logic                          FlushE_o,
  output logic [1:0]                    ForwardAE_o,
  output logic [1:0]                    ForwardBE_o,
  output logic [CNT_WIDTH-1:0]          stall_cnt_o
);

  mem_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           fwd_a, fwd_b;
  logic                 lw_stall;
  logic                 mem_freeze;

  fwd_unit #(.ADDR_W(REGISTER_ADDR_SIZE)) u_fwd_a (
    .rs_i          (Rs1E_i),
    .rd_m_i        (RdM_i),
    .rd_w_i        (RdW_i),
    .reg_write_m_i (RegWriteM_i),
    .reg_write_w_i (RegWriteW_i),
    .fwd_o         (fwd_a)
  );

  fwd_unit #(.ADDR_W(REGISTER_ADDR_SIZE)) u_fwd_b (
    .rs_i          (Rs2E_i),
    .rd_m_i        (RdM_i),
    .rd_w_i        (RdW_i),
    .reg_write_m_i (RegWriteM_i),
    .reg_write_w_i (RegWriteW_i),
    .fwd_o         (fwd_b)
  );

  assign lw_stall = (ResultSrcE_i == RESULT_SRC_LOAD) && (RdE_i != '0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  // Memory FSM next state, valid, freeze and pipeline controls.
  always_comb begin
    state_d     = state_q;
    mem_valid_o = 1'b0;
    EnF_o       = 1'b1;
    EnD_o       = 1'b1;
    EnE_o       = 1'b1;
    EnM_o       = 1'b1;
    EnW_o       = 1'b1;
    FlushD_o    = 1'b0;
    FlushE_o    = 1'b0;
    ForwardAE_o = fwd_a;
    ForwardBE_o = fwd_b;
    cnt_d       = cnt_q;

    case (state_q)
      RUN: begin
        mem_valid_o = MemReqM_i;
        if (MemReqM_i && !mem_ready_i) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        mem_valid_o = 1'b1;
        if (mem_ready_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (rst_i) begin
      // Reset abandons any outstanding access and drops valid at once.
      state_d     = RUN;
      mem_valid_o = 1'b0;
      FlushD_o    = 1'b1;
      FlushE_o    = 1'b1;
      ForwardAE_o = FWD_RF;
      ForwardBE_o = FWD_RF;
      cnt_d       = '0;
    end else begin
      if (mem_freeze) begin
        EnF_o = 1'b0;
        EnD_o = 1'b0;
        EnE_o = 1'b0;
        EnM_o = 1'b0;
        EnW_o = 1'b0;
      end else if (PCSrcE_i) begin
        // Branch wins over load-use: the stalled decode op is discarded anyway.
        FlushD_o = 1'b1;
        FlushE_o = 1'b1;
      end else if (lw_stall) begin
        EnF_o    = 1'b0;
        EnD_o    = 1'b0;
        FlushE_o = 1'b1;
      end

      if ((mem_freeze || (lw_stall && !PCSrcE_i)) && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign mem_freeze  = mem_valid_o && !mem_ready_i;
  assign stall_cnt_o = cnt_q;

  // State and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import pipeline_pkg::*;

  logic       clk;
  logic       rst_i;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, RegWriteW, PCSrcE, MemReqM, mem_ready;

  logic        mem_valid, EnF, EnD, EnE, EnM, EnW, FlushD, FlushE;
  logic [1:0]  FwdA, FwdB;
  logic [15:0] cnt;

  logic        s_mem_valid, s_EnF, s_EnD, s_EnE, s_EnM, s_EnW, s_FlushD, s_FlushE;
  logic [1:0]  s_FwdA, s_FwdB;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  hazard_ctrl #(.REGISTER_ADDR_SIZE(5), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
    .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW), .ResultSrcE_i(ResultSrcE),
    .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW), .PCSrcE_i(PCSrcE),
    .MemReqM_i(MemReqM), .mem_ready_i(mem_ready), .mem_valid_o(mem_valid),
    .EnF_o(EnF), .EnD_o(EnD), .EnE_o(EnE), .EnM_o(EnM), .EnW_o(EnW),
    .FlushD_o(FlushD), .FlushE_o(FlushE),
    .ForwardAE_o(FwdA), .ForwardBE_o(FwdB), .stall_cnt_o(cnt)
  );

  hazard_ctrl #(.REGISTER_ADDR_SIZE(5), .CNT_WIDTH(4)) u_sat (
    .clk_i(clk), .rst_i(rst_i),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
    .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW), .ResultSrcE_i(ResultSrcE),
    .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW), .PCSrcE_i(PCSrcE),
    .MemReqM_i(MemReqM), .mem_ready_i(mem_ready), .mem_valid_o(s_mem_valid),
    .EnF_o(s_EnF), .EnD_o(s_EnD), .EnE_o(s_EnE), .EnM_o(s_EnM), .EnW_o(s_EnW),
    .FlushD_o(s_FlushD), .FlushE_o(s_FlushE),
    .ForwardAE_o(s_FwdA), .ForwardBE_o(s_FwdB), .stall_cnt_o(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector {EnF,EnD,EnE,EnM,EnW,FlushD,FlushE}
  function automatic logic [6:0] ctl();
    return {EnF, EnD, EnE, EnM, EnW, FlushD, FlushE};
  endfunction

  task automatic idle_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00;
    RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
    MemReqM = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_i = 1'b1;
    RdM = 5'd7; Rs1E = 5'd7; Rs2E = 5'd7; RegWriteM = 1'b1; MemReqM = 1'b1;
    #1;
    checks++;
    if ({mem_valid, ctl(), FwdA, FwdB} !== {1'b0, 7'b1111111, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b ctl=%b fa=%b fb=%b exp valid=0 ctl=1111111 fa=00 fb=00",
               mem_valid, ctl(), FwdA, FwdB);
    end
    checks++;
    if (cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d exp 0", cnt);
    end
    @(negedge clk);
    rst_i = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if ({mem_valid, ctl(), FwdA, FwdB} !== {1'b0, 7'b1111100, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL post_reset_normal got valid=%b ctl=%b fa=%b fb=%b exp valid=0 ctl=1111100",
               mem_valid, ctl(), FwdA, FwdB);
    end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
    #1;
    checks++;
    if ({FwdA, FwdB} !== {2'b10, 2'b10}) begin
      errors++; $display("FAIL fwd_m_priority got fa=%b fb=%b exp 10 10", FwdA, FwdB);
    end
    RegWriteM = 1'b0;
    #1;
    checks++;
    if ({FwdA, FwdB} !== {2'b01, 2'b01}) begin
      errors++; $display("FAIL fwd_w got fa=%b fb=%b exp 01 01", FwdA, FwdB);
    end
    RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    #1;
    checks++;
    if ({FwdA, FwdB} !== {2'b00, 2'b00}) begin
      errors++; $display("FAIL fwd_x0 got fa=%b fb=%b exp 00 00", FwdA, FwdB);
    end
    RdM = 5'd9; RdW = 5'd4; Rs1E = 5'd4; Rs2E = 5'd9;
    #1;
    checks++;
    if ({FwdA, FwdB} !== {2'b01, 2'b10}) begin
      errors++; $display("FAIL fwd_split got fa=%b fb=%b exp 01 10", FwdA, FwdB);
    end
    RdM = 5'd9; RdW = 5'd4; Rs1E = 5'd12; Rs2E = 5'd13;
    #1;
    checks++;
    if ({FwdA, FwdB} !== {2'b00, 2'b00}) begin
      errors++; $display("FAIL fwd_nomatch got fa=%b fb=%b exp 00 00", FwdA, FwdB);
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ResultSrcE = 2'b01; RdE = 5'd3; Rs2D = 5'd3; Rs1D = 5'd8;
    #1;
    checks++;
    if (ctl() !== 7'b0011101) begin
      errors++; $display("FAIL lw_stall_ctl got %b exp 0011101", ctl());
    end
    exp_cnt++;
    @(negedge clk);
    checks++;
    if (cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL lw_stall_cnt got %0d exp %0d", cnt, exp_cnt);
    end
    ResultSrcE = 2'b00;
    #1;
    checks++;
    if (ctl() !== 7'b1111100) begin
      errors++; $display("FAIL lw_release_ctl got %b exp 1111100", ctl());
    end
    @(negedge clk);
    checks++;
    if (cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL lw_release_cnt got %0d exp %0d", cnt, exp_cnt);
    end
    // Rs1D match also stalls; RdE = x0 does not.
    ResultSrcE = 2'b01; RdE = 5'd6; Rs1D = 5'd6; Rs2D = 5'd1;
    #1;
    checks++;
    if (ctl() !== 7'b0011101) begin
      errors++; $display("FAIL lw_rs1_ctl got %b exp 0011101", ctl());
    end
    exp_cnt++;
    @(negedge clk);
    RdE = 5'd0; Rs1D = 5'd0;
    #1;
    checks++;
    if (ctl() !== 7'b1111100) begin
      errors++; $display("FAIL lw_x0_ctl got %b exp 1111100", ctl());
    end
    @(negedge clk);
    checks++;
    if (cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL lw_x0_cnt got %0d exp %0d", cnt, exp_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_branch_vs_lw();
    @(negedge clk);
    ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3; PCSrcE = 1'b1;
    #1;
    checks++;
    if (ctl() !== 7'b1111111) begin
      errors++; $display("FAIL branch_over_lw got %b exp 1111111", ctl());
    end
    @(negedge clk);
    checks++;
    if (cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL branch_cnt got %0d exp %0d", cnt, exp_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      MemReqM = 1'b1; mem_ready = (i == 3);
      #1;
      checks++;
      if ({mem_valid, ctl()} !== ((i == 3) ? 8'b1_1111100 : 8'b1_0000000)) begin
        errors++; $display("FAIL mem_wait_cyc%0d got valid=%b ctl=%b", i, mem_valid, ctl());
      end
      if (i == 1) begin
        checks++;
        if (dut.state_q !== MEM_WAIT) begin
          errors++; $display("FAIL mem_wait_state got %b exp MEM_WAIT", dut.state_q);
        end
      end
    end
    exp_cnt += 3;
    @(negedge clk);
    checks++;
    if ((dut.state_q !== RUN) || (cnt !== 16'(exp_cnt))) begin
      errors++; $display("FAIL mem_done got state=%b cnt=%0d exp RUN %0d", dut.state_q, cnt, exp_cnt);
    end
    MemReqM = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if ({mem_valid, ctl()} !== 8'b0_1111100) begin
      errors++; $display("FAIL mem_idle got valid=%b ctl=%b exp 0 1111100", mem_valid, ctl());
    end
    // Same-cycle ready: no stall.
    @(negedge clk);
    MemReqM = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if ({mem_valid, ctl()} !== 8'b1_1111100) begin
      errors++; $display("FAIL mem_fast got valid=%b ctl=%b exp 1 1111100", mem_valid, ctl());
    end
    @(negedge clk);
    checks++;
    if ((dut.state_q !== RUN) || (cnt !== 16'(exp_cnt))) begin
      errors++; $display("FAIL mem_fast_after got state=%b cnt=%0d exp RUN %0d", dut.state_q, cnt, exp_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_freeze_branch();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      MemReqM = 1'b1; PCSrcE = 1'b1; mem_ready = (i == 2);
      #1;
      checks++;
      if (ctl() !== ((i == 2) ? 7'b1111111 : 7'b0000000)) begin
        errors++; $display("FAIL freeze_branch_cyc%0d got %b", i, ctl());
      end
    end
    exp_cnt += 2;
    @(negedge clk);
    checks++;
    if (cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL freeze_branch_cnt got %0d exp %0d", cnt, exp_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    MemReqM = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state_q !== MEM_WAIT) begin
      errors++; $display("FAIL rst_wait_entry got %b exp MEM_WAIT", dut.state_q);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({mem_valid, ctl()} !== 8'b0_1111111) begin
      errors++; $display("FAIL rst_wait_drop got valid=%b ctl=%b exp 0 1111111", mem_valid, ctl());
    end
    @(negedge clk);
    rst_i = 1'b0; MemReqM = 1'b0;
    #1;
    checks++;
    if ((dut.state_q !== RUN) || (cnt !== 16'd0) || (mem_valid !== 1'b0)) begin
      errors++; $display("FAIL rst_wait_after got state=%b cnt=%0d valid=%b exp RUN 0 0",
                         dut.state_q, cnt, mem_valid);
    end
    exp_cnt = 0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      MemReqM = 1'b1; mem_ready = 1'b0;
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++;
    if (s_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_small got %0d exp 15", s_cnt);
    end
    checks++;
    if (cnt !== 16'd20) begin
      errors++; $display("FAIL sat_wide got %0d exp 20", cnt);
    end
    @(negedge clk);
    checks++;
    if (s_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_hold got %0d exp 15", s_cnt);
    end
    idle_inputs();
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_lw();
    test_mem_wait();
    test_freeze_branch();
    test_reset_in_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
